// File: rtl/arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding
// and the port identifiers used for owner/grant values.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic OWNER_C = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational two-way picker: grants the single requester, or on a tie
// either port C (fixed priority) or the port that did not win last time.
module rr_pick
    import arb_pkg::*;
(
    input  logic req_c,
    input  logic req_d,
    input  logic last,
    input  logic fixed,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req_c | req_d;
        if (req_c && req_d) begin
            grant_id = fixed ? OWNER_C : ~last;
        end else if (req_d) begin
            grant_id = OWNER_D;
        end else begin
            grant_id = OWNER_C;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single instruction/data memory between the processor (port C)
// and a second master (port D), sequencing each grant through ISSUE/WAIT/DONE.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 1,
    parameter bit CPU_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ready,
    output logic [DW-1:0] c_rdata,
    output logic          c_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_adr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output logic          owner
);

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    arb_state_t    state;
    logic [2:0]    cnt;
    logic          we_q;
    logic          grant_valid;
    logic          grant_id;
    logic          sel_we;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_wdata;

    rr_pick u_pick (
        .req_c       (c_req),
        .req_d       (d_req),
        .last        (owner),
        .fixed       (CPU_PRIO),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_we    = (grant_id == OWNER_D) ? d_we    : c_we;
    assign sel_adr   = (grant_id == OWNER_D) ? d_adr   : c_adr;
    assign sel_wdata = (grant_id == OWNER_D) ? d_wdata : c_wdata;

    assign busy    = (state != IDLE);
    assign c_stall = c_req & ~c_ready;

    // The counter runs down from MEM_LAT-1 starting in ISSUE, so the read data
    // is sampled on the MEM_LAT-th edge after the grant and ready follows it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            owner   <= OWNER_D;
            cnt     <= '0;
            we_q    <= 1'b0;
            m_adr   <= '0;
            m_wdata <= '0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            c_ready <= 1'b0;
            d_ready <= 1'b0;
            c_rdata <= '0;
            d_rdata <= '0;
        end else begin
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            c_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state   <= ISSUE;
                        owner   <= grant_id;
                        cnt     <= CNT_INIT;
                        we_q    <= sel_we;
                        m_adr   <= sel_adr;
                        m_wdata <= sel_wdata;
                        m_en    <= 1'b1;
                        m_we    <= sel_we;
                    end
                end
                ISSUE, WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= DONE;
                        if (!we_q) begin
                            if (owner == OWNER_D) begin
                                d_rdata <= m_rdata;
                            end else begin
                                c_rdata <= m_rdata;
                            end
                        end
                        if (owner == OWNER_D) begin
                            d_ready <= 1'b1;
                        end else begin
                            c_ready <= 1'b1;
                        end
                    end else begin
                        state <= WAIT;
                        cnt   <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: instance 0 is MEM_LAT=1 round-robin,
// instance 1 is MEM_LAT=3 fixed priority; both are tracked by a cycle model.
module tb_mem_arbiter;

    logic              clk;
    logic              reset;
    logic [1:0]        c_req, d_req, c_we, d_we;
    logic [1:0][31:0]  c_adr, d_adr, c_wdata, d_wdata, m_rdata;
    logic [1:0]        c_ready, d_ready, c_stall, m_en, m_we, busy, owner;
    logic [1:0][31:0]  c_rdata, d_rdata, m_adr, m_wdata;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    // Reference model: pos counts cycles since the grant (0 = idle,
    // 1 = strobe cycle, lat+1 = completion cycle).
    int          pos   [2];
    bit          own_m [2];
    bit          we_m  [2];
    logic [31:0] adr_m [2];
    logic [31:0] wd_m  [2];
    logic [31:0] rd_m  [2][2];

    typedef struct {
        int          inst;
        bit          c;
        bit          d;
        bit          cwe;
        bit          dwe;
        logic [31:0] adr;
        bit          exp_owner;
    } vec_t;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit prio_of(input int k);
        return (k == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a ^ 32'hC0DE0000) + 32'h1234;
    endfunction

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .CPU_PRIO(1'b0)) u_arb0 (
        .clk(clk), .reset(reset),
        .c_req(c_req[0]), .c_we(c_we[0]), .c_adr(c_adr[0]), .c_wdata(c_wdata[0]),
        .c_ready(c_ready[0]), .c_rdata(c_rdata[0]), .c_stall(c_stall[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_adr(d_adr[0]), .d_wdata(d_wdata[0]),
        .d_ready(d_ready[0]), .d_rdata(d_rdata[0]),
        .m_en(m_en[0]), .m_we(m_we[0]), .m_adr(m_adr[0]), .m_wdata(m_wdata[0]),
        .m_rdata(m_rdata[0]), .busy(busy[0]), .owner(owner[0])
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .CPU_PRIO(1'b1)) u_arb1 (
        .clk(clk), .reset(reset),
        .c_req(c_req[1]), .c_we(c_we[1]), .c_adr(c_adr[1]), .c_wdata(c_wdata[1]),
        .c_ready(c_ready[1]), .c_rdata(c_rdata[1]), .c_stall(c_stall[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_adr(d_adr[1]), .d_wdata(d_wdata[1]),
        .d_ready(d_ready[1]), .d_rdata(d_rdata[1]),
        .m_en(m_en[1]), .m_we(m_we[1]), .m_adr(m_adr[1]), .m_wdata(m_wdata[1]),
        .m_rdata(m_rdata[1]), .busy(busy[1]), .owner(owner[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        m_rdata[0] = mem_fn(m_adr[0]);
        m_rdata[1] = mem_fn(m_adr[1]);
    end

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                pos[k]      = 0;
                own_m[k]    = 1'b1;
                we_m[k]     = 1'b0;
                adr_m[k]    = '0;
                wd_m[k]     = '0;
                rd_m[k][0]  = '0;
                rd_m[k][1]  = '0;
            end else if (pos[k] == 0) begin
                if (c_req[k] || d_req[k]) begin
                    own_m[k] = (c_req[k] && d_req[k]) ? (prio_of(k) ? 1'b0 : !own_m[k]) : d_req[k];
                    we_m[k]  = own_m[k] ? d_we[k]    : c_we[k];
                    adr_m[k] = own_m[k] ? d_adr[k]   : c_adr[k];
                    wd_m[k]  = own_m[k] ? d_wdata[k] : c_wdata[k];
                    pos[k]   = 1;
                end
            end else begin
                if (pos[k] == lat_of(k) && !we_m[k]) rd_m[k][own_m[k]] = mem_fn(adr_m[k]);
                pos[k] = (pos[k] == lat_of(k) + 1) ? 0 : pos[k] + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Every cycle while enabled, both instances are compared against the model.
    always begin
        @(posedge clk);
        #1;
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                automatic bit er_c = (pos[k] == lat_of(k) + 1) && !own_m[k];
                automatic bit er_d = (pos[k] == lat_of(k) + 1) && own_m[k];
                checkOutput($sformatf("u%0d_busy", k),    32'(busy[k]),    32'(pos[k] != 0));
                checkOutput($sformatf("u%0d_m_en", k),    32'(m_en[k]),    32'(pos[k] == 1));
                checkOutput($sformatf("u%0d_m_we", k),    32'(m_we[k]),    32'(pos[k] == 1 && we_m[k]));
                checkOutput($sformatf("u%0d_m_adr", k),   m_adr[k],        adr_m[k]);
                checkOutput($sformatf("u%0d_m_wdata", k), m_wdata[k],      wd_m[k]);
                checkOutput($sformatf("u%0d_owner", k),   32'(owner[k]),   32'(own_m[k]));
                checkOutput($sformatf("u%0d_c_ready", k), 32'(c_ready[k]), 32'(er_c));
                checkOutput($sformatf("u%0d_d_ready", k), 32'(d_ready[k]), 32'(er_d));
                checkOutput($sformatf("u%0d_c_rdata", k), c_rdata[k],      rd_m[k][0]);
                checkOutput($sformatf("u%0d_d_rdata", k), d_rdata[k],      rd_m[k][1]);
                checkOutput($sformatf("u%0d_c_stall", k), 32'(c_stall[k]), 32'(c_req[k] && !er_c));
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        automatic int k   = v.inst;
        automatic int n   = 0;
        automatic bit got = 1'b0;
        c_req[k]   = v.c;
        d_req[k]   = v.d;
        c_we[k]    = v.cwe;
        d_we[k]    = v.dwe;
        c_adr[k]   = v.adr;
        d_adr[k]   = v.adr + 32'd4;
        c_wdata[k] = v.adr ^ 32'h0000FFFF;
        d_wdata[k] = ~v.adr;
        while (!got && n < 20) begin
            tick();
            n++;
            got = c_ready[k] | d_ready[k];
        end
        checkOutput($sformatf("txn_u%0d_done", k), 32'(got), 32'd1);
        checkOutput($sformatf("txn_u%0d_owner", k), 32'(owner[k]), 32'(v.exp_owner));
        checkOutput($sformatf("txn_u%0d_ready_port", k), 32'(d_ready[k]), 32'(v.exp_owner));
        checkOutput($sformatf("txn_u%0d_latency", k), 32'(n), 32'(lat_of(k) + 1));
        c_req[k] = 1'b0;
        d_req[k] = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [10];
        int   n;
        int   nrdy;
        int   wcount;
        bit   got;
        logic [31:0] exp_rd;
        int   grants [$];

        vecs[0] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 1'b0};
        vecs[1] = '{0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 1'b1};
        vecs[2] = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0030, 1'b1};
        vecs[3] = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0};
        vecs[4] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0050, 1'b0};
        vecs[5] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0060, 1'b1};
        vecs[6] = '{1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0070, 1'b0};
        vecs[7] = '{1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 1'b0};
        vecs[8] = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0090, 1'b1};
        vecs[9] = '{1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00A0, 1'b0};

        reset   = 1'b0;
        c_req   = '0; d_req = '0; c_we = '0; d_we = '0;
        c_adr   = '0; d_adr = '0; c_wdata = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_busy",  32'(busy),    32'd0);
        checkOutput("rst_m_en",  32'(m_en),    32'd0);
        checkOutput("rst_owner", 32'(owner),   32'd3);
        checkOutput("rst_ready", 32'({c_ready, d_ready}), 32'd0);
        checkOutput("rst_rdata", c_rdata[1] | d_rdata[0], 32'd0);
        checkOutput("rst_m_adr", m_adr[0] | m_wdata[1], 32'd0);
        reset  = 1'b1;
        chk_on = 1'b1;
        tick();

        // Arbitration table: round-robin alternation and fixed-priority ties
        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        // Single C read at 0x100 on the MEM_LAT=1 instance
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_adr[0] = 32'h100;
        tick();
        checkOutput("rd100_m_en_c1",  32'(m_en[0]),    32'd1);
        checkOutput("rd100_m_adr",    m_adr[0],        32'h100);
        checkOutput("rd100_stall_c1", 32'(c_stall[0]), 32'd1);
        tick();
        checkOutput("rd100_m_en_c2",  32'(m_en[0]),    32'd0);
        checkOutput("rd100_c_ready",  32'(c_ready[0]), 32'd1);
        checkOutput("rd100_c_rdata",  c_rdata[0],      32'hDEADBEEF);
        checkOutput("rd100_d_ready",  32'(d_ready[0]), 32'd0);
        checkOutput("rd100_stall_c2", 32'(c_stall[0]), 32'd0);
        c_req[0] = 1'b0;
        tick();

        // D write on the MEM_LAT=3 instance: one strobe, ready at cycle 4
        exp_rd   = rd_m[1][1];
        wcount   = 0;
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_adr[1] = 32'h40; d_wdata[1] = 32'h55;
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (m_we[1]) wcount++;
            if (t == 1) begin
                checkOutput("wr_m_we_c1",   32'(m_we[1]), 32'd1);
                checkOutput("wr_m_adr",     m_adr[1],     32'h40);
                checkOutput("wr_m_wdata",   m_wdata[1],   32'h55);
            end
            if (t == 4) begin
                checkOutput("wr_d_ready_c4", 32'(d_ready[1]), 32'd1);
                checkOutput("wr_d_rdata",    d_rdata[1],      exp_rd);
            end
        end
        checkOutput("wr_we_pulses", 32'(wcount), 32'd1);
        d_req[1] = 1'b0; d_we[1] = 1'b0;
        tick();

        // C holds req for three reads: grants spaced MEM_LAT+2 apart
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_adr[0] = 32'h200;
        nrdy = 0;
        for (int t = 1; t <= 20 && nrdy < 3; t++) begin
            tick();
            if (m_en[0]) grants.push_back(t);
            if (c_ready[0]) nrdy++;
            checkOutput("hold_stall", 32'(c_stall[0]), 32'((t % 3) != 2));
        end
        c_req[0] = 1'b0;
        tick();
        checkOutput("hold_grants", 32'(grants.size()), 32'd3);
        if (grants.size() == 3) begin
            checkOutput("hold_space1", 32'(grants[1] - grants[0]), 32'd3);
            checkOutput("hold_space2", 32'(grants[2] - grants[1]), 32'd3);
        end

        // Asynchronous reset in WAIT aborts the access without a ready pulse
        c_req[1] = 1'b1; c_we[1] = 1'b0; c_adr[1] = 32'h300;
        tick();
        tick();
        #3;
        reset = 1'b0;
        #1;
        checkOutput("arst_busy",    32'(busy[1]),    32'd0);
        checkOutput("arst_m_en",    32'(m_en[1]),    32'd0);
        checkOutput("arst_c_ready", 32'(c_ready[1]), 32'd0);
        checkOutput("arst_owner",   32'(owner[1]),   32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            got = c_ready[1];
        end
        checkOutput("arst_recover_done",  32'(got),   32'd1);
        checkOutput("arst_recover_lat",   32'(n),     32'd4);
        checkOutput("arst_recover_rdata", c_rdata[1], mem_fn(32'h300));
        c_req[1] = 1'b0;
        tick();

        // Random traffic on both instances, including one async reset pulse
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 2; k++) begin
                c_req[k]   = 1'($urandom_range(0, 1));
                d_req[k]   = 1'($urandom_range(0, 1));
                c_we[k]    = 1'($urandom_range(0, 1));
                d_we[k]    = 1'($urandom_range(0, 1));
                c_adr[k]   = $urandom;
                d_adr[k]   = $urandom;
                c_wdata[k] = $urandom;
                d_wdata[k] = $urandom;
            end
            if (i == 150) begin
                #3 reset = 1'b0;
                #2 reset = 1'b1;
            end
            tick();
        end
        c_req = '0;
        d_req = '0;
        repeat (8) tick();
        chk_on = 1'b0;

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
